// File: rtl/fir2d_pkg.sv
// Shared types, widths and constant generators for the K x K FIR engine.
// Widths are functions of the kernel size so every file derives them the same way.
package fir2d_pkg;

  localparam int KMAX   = 7;
  localparam int ADDR_W = 6;
  localparam int BUS_W  = 32;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_LOAD,
    LD_DONE
  } load_state_e;

  function automatic int tree_depth(input int k);
    return $clog2(k * k);
  endfunction

  function automatic int acc_width(input int k, input int pw, input int cw);
    return pw + 1 + cw + tree_depth(k);
  endfunction

  // Flat kernel with stride cw: centre tap = 1.0 in Q(frac), every other tap 0.
  function automatic logic [KMAX*KMAX*BUS_W-1:0] identity_kernel(input int k, input int cw,
                                                                 input int frac);
    logic [KMAX*KMAX*BUS_W-1:0] v;
    int centre;
    v      = '0;
    centre = (k / 2) * k + k / 2;
    for (int b = 0; b < cw; b++) v[centre*cw+b] = (b == frac);
    return v;
  endfunction

endpackage

// File: rtl/fir2d_coeff_loader.sv
// Coefficient loader: fills a shadow bank from BRAM during vertical blanking and
// commits it to the active bank on the falling edge of vs, so a frame never mixes kernels.
module fir2d_coeff_loader
  import fir2d_pkg::*;
#(
  parameter int K    = 5,
  parameter int CW   = 16,
  parameter int FRAC = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vs_i,
  input  logic [CW-1:0]       coeff_data_i,
  output logic [ADDR_W-1:0]   coeff_addr_o,
  output logic                coeff_busy_o,
  output logic                coeff_err_o,
  output logic [K*K*CW-1:0]   active_o
);

  localparam int NTAP = K * K;
  localparam logic [KMAX*KMAX*BUS_W-1:0] IDENT_FULL = identity_kernel(K, CW, FRAC);
  localparam logic [NTAP*CW-1:0] IDENT = IDENT_FULL[NTAP*CW-1:0];
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NTAP - 1);

  load_state_e        state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  cap_idx_q, cap_idx_d;
  logic               issue_q, issue_d;
  logic               cap_en_q, cap_en_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               vs_prev_q;
  logic [NTAP*CW-1:0] shadow_q, shadow_d;
  logic [NTAP*CW-1:0] active_q, active_d;
  logic               vs_rise, vs_fall;

  assign vs_rise = vs_i & ~vs_prev_q;
  assign vs_fall = ~vs_i & vs_prev_q;

  always_comb begin
    // NOTE: every *_d takes its hold value first, so no branch can leave one unassigned (no latch).
    state_d   = state_q;
    addr_d    = addr_q;
    cap_idx_d = cap_idx_q;
    issue_d   = issue_q;
    cap_en_d  = cap_en_q;
    busy_d    = busy_q;
    err_d     = err_q;
    shadow_d  = shadow_q;
    active_d  = active_q;

    if (vs_rise && state_q != LD_LOAD || vs_rise) begin
      state_d  = LD_LOAD;
      addr_d   = '0;
      issue_d  = 1'b1;
      cap_en_d = 1'b0;
      busy_d   = 1'b1;
    end else begin
      case (state_q)
        LD_LOAD: begin
          if (vs_fall) begin
            state_d  = LD_IDLE;
            err_d    = 1'b1;
            busy_d   = 1'b0;
            addr_d   = '0;
            issue_d  = 1'b0;
            cap_en_d = 1'b0;
          end else begin
            // Data for the address issued last cycle arrives now (1-cycle BRAM latency).
            cap_en_d  = issue_q;
            cap_idx_d = addr_q;
            if (issue_q) begin
              if (addr_q == LAST_ADDR) begin
                issue_d = 1'b0;
                addr_d  = '0;
              end else begin
                addr_d = addr_q + ADDR_W'(1);
              end
            end
            if (cap_en_q) begin
              shadow_d[int'(cap_idx_q)*CW +: CW] = coeff_data_i;
              if (cap_idx_q == LAST_ADDR) begin
                state_d  = LD_DONE;
                busy_d   = 1'b0;
                cap_en_d = 1'b0;
              end
            end
          end
        end
        LD_DONE: begin
          if (vs_fall) begin
            active_d = shadow_q;
            state_d  = LD_IDLE;
          end
        end
        default: state_d = LD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= LD_IDLE;
      addr_q    <= '0;
      cap_idx_q <= '0;
      issue_q   <= 1'b0;
      cap_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      vs_prev_q <= 1'b0;
      // NOTE: both banks are plain flops, not RAM, so they can be reset to the identity kernel.
      shadow_q  <= IDENT;
      active_q  <= IDENT;
    end else begin
      // NOTE: sequential state only ever uses <=; next-state values are built with = in always_comb.
      state_q   <= state_d;
      addr_q    <= addr_d;
      cap_idx_q <= cap_idx_d;
      issue_q   <= issue_d;
      cap_en_q  <= cap_en_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      vs_prev_q <= vs_i;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
    end
  end

  assign coeff_addr_o = addr_q;
  assign coeff_busy_o = busy_q;
  assign coeff_err_o  = err_q;
  assign active_o     = active_q;

endmodule

// File: rtl/fir2d_kernel_engine.sv
// K x K 2D FIR datapath: sliding window, signed multipliers, pipelined adder tree,
// round/saturate, with dv/hs/vs delay-matched to the pixel latency 3 + clog2(K*K).
module fir2d_kernel_engine
  import fir2d_pkg::*;
#(
  parameter int K        = 5,
  parameter int PW       = 8,
  parameter int CW       = 16,
  parameter int FRAC     = 8,
  parameter int ABS_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [K*PW-1:0]   col_i,
  input  logic              dv_i,
  input  logic              hs_i,
  input  logic              vs_i,
  input  logic [BUS_W-1:0]  coeff_data_i,
  output logic [ADDR_W-1:0] coeff_addr_o,
  output logic [PW-1:0]     r_o,
  output logic [PW-1:0]     g_o,
  output logic [PW-1:0]     b_o,
  output logic              dv_o,
  output logic              hs_o,
  output logic              vs_o,
  output logic              coeff_busy_o,
  output logic              coeff_err_o
);

  localparam int NTAP   = K * K;
  localparam int DEPTH  = tree_depth(K);
  localparam int LEAVES = 1 << DEPTH;
  localparam int ACCW   = acc_width(K, PW, CW);
  localparam int LAT    = 3 + DEPTH;
  localparam logic signed [ACCW-1:0] RND_C     = ACCW'(2 ** (FRAC - 1));
  localparam logic signed [ACCW-1:0] PIX_MAX_C = ACCW'(2 ** PW - 1);

  logic [NTAP*CW-1:0]     coeff_act;
  logic                   unused_bus_bits;
  logic [PW-1:0]          win_q  [K][K];
  logic [PW-1:0]          win_d  [K][K];
  logic signed [ACCW-1:0] tree_q [DEPTH+1][LEAVES];
  logic signed [ACCW-1:0] tree_d [DEPTH+1][LEAVES];
  logic signed [PW+CW:0]  prod;
  logic signed [ACCW-1:0] sum_rnd, mag;
  logic [PW-1:0]          pix_q, pix_d;
  logic [2:0]             sync_q [LAT];
  logic [2:0]             sync_d [LAT];

  assign unused_bus_bits = ^coeff_data_i[BUS_W-1:CW];

  fir2d_coeff_loader #(
    .K    (K),
    .CW   (CW),
    .FRAC (FRAC)
  ) u_loader (
    .clk          (clk),
    .rst_n        (rst_n),
    .vs_i         (vs_i),
    .coeff_data_i (coeff_data_i[CW-1:0]),
    .coeff_addr_o (coeff_addr_o),
    .coeff_busy_o (coeff_busy_o),
    .coeff_err_o  (coeff_err_o),
    .active_o     (coeff_act)
  );

  // Window shifts every cycle regardless of dv; column K-1 holds the newest pixel column.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) win_d[r][c] = win_q[r][c+1];
      win_d[r][K-1] = col_i[r*PW +: PW];
    end
  end

  // Level 0 holds the products; each further level halves the count, unused leaves stay 0.
  always_comb begin
    prod = '0;
    for (int l = 0; l <= DEPTH; l++)
      for (int i = 0; i < LEAVES; i++) tree_d[l][i] = '0;
    for (int i = 0; i < NTAP; i++) begin
      prod = $signed({1'b0, win_q[i/K][i%K]}) * $signed(coeff_act[i*CW +: CW]);
      tree_d[0][i] = ACCW'(prod);
    end
    for (int l = 1; l <= DEPTH; l++)
      for (int i = 0; i < (LEAVES >> l); i++)
        tree_d[l][i] = tree_q[l-1][2*i] + tree_q[l-1][2*i+1];
  end

  always_comb begin
    sum_rnd = (tree_q[DEPTH][0] + RND_C) >>> FRAC;
    mag     = (ABS_MODE != 0 && sum_rnd < 0) ? -sum_rnd : sum_rnd;
    if (mag < 0)              pix_d = '0;
    else if (mag > PIX_MAX_C) pix_d = '1;
    else                      pix_d = mag[PW-1:0];
  end

  always_comb begin
    sync_d[0] = {dv_i, hs_i, vs_i};
    for (int i = 1; i < LAT; i++) sync_d[i] = sync_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win_q[r][c] <= '0;
      for (int l = 0; l <= DEPTH; l++)
        for (int i = 0; i < LEAVES; i++) tree_q[l][i] <= '0;
      for (int i = 0; i < LAT; i++) sync_q[i] <= '0;
      pix_q <= '0;
    end else begin
      win_q  <= win_d;
      tree_q <= tree_d;
      sync_q <= sync_d;
      pix_q  <= pix_d;
    end
  end

  assign r_o = pix_q;
  assign g_o = pix_q;
  assign b_o = pix_q;
  assign {dv_o, hs_o, vs_o} = sync_q[LAT-1];

endmodule

// File: doc/fir2d_kernel_engine.md
# fir2d_kernel_engine

Parametrised K×K 2D FIR datapath for the grayscale video pipeline. Consumes one vertical pixel column per clock from the line-buffer stage and holds a K×K sliding window. Computes a signed fixed-point convolution with rounding and saturation, then drives the replicated gray result on R/G/B with sync signals delay-matched. Coefficients are loaded from the coefficient BRAM during vertical blanking into a shadow bank and committed atomically at frame start, so no frame ever mixes two kernels.

## Interface
- K, 5: kernel size; odd, 3..7 (K*K ≤ 64 fits 6-bit address).
- PW, 8: pixel width, unsigned.
- CW, 16: coefficient width, signed, taken from coeff_data_i[CW-1:0].
- FRAC, 8: coefficient fractional bits (Q8.8 at defaults).
- ABS_MODE, 0: 0 = clip signed result to [0, 2^PW-1]; 1 = take magnitude, then clip.
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- col_i  in  K*PW  current column; slice [PW-1:0] is row 0 (oldest line).
- dv_i, hs_i, vs_i  in  1 each  video syncs aligned to col_i; vs_i active-high during blanking.
- coeff_data_i  in  32  BRAM read data, 1-cycle read latency.
- coeff_addr_o  out  6  BRAM address; coefficient (r,c) at r*K+c.
- r_o, g_o, b_o  out  PW each  filtered pixel, all three equal.
- dv_o, hs_o, vs_o  out  1 each  syncs delayed by latency L.
- coeff_busy_o  out  1  shadow load in progress.
- coeff_err_o  out  1  sticky; set when a load is missed. Cleared only by reset.

## Operation
- Window: K×K register array. Every cycle, columns shift by one and col_i enters column K-1. Shifting is unconditional and does not depend on dv_i.
- Multiply: each window pixel is zero-extended to PW+1 signed and multiplied by its active coefficient.
- Sum: pipelined adder tree. Accumulator width ACCW = PW+1+CW+clog2(K*K); no overflow possible.
- Round: res = (acc + 2^(FRAC-1)) >>> FRAC, arithmetic shift.
- Saturate: in ABS_MODE=1, first res = |res|. Then res<0 → 0 and res>2^PW-1 → 2^PW-1.
- Loader FSM (IDLE, LOAD, DONE):
  - IDLE: on vs_i rising edge → LOAD with addr=0; coeff_busy_o=1.
  - LOAD: issues addr 0..K*K-1, one per cycle. Captures data one cycle later into shadow[addr-1]. After the last capture → DONE; busy=0.
  - DONE: on vs_i falling edge, shadow→active in one cycle → IDLE.
  - vs_i falling edge while in LOAD: no commit, coeff_err_o set, active bank unchanged, FSM → IDLE.
  - vs_i rising edge while in LOAD or DONE: restart LOAD from addr 0.
- coeff_addr_o holds 0 when not loading.

## Timing
- Latency L = 3 + clog2(K*K) cycles, col_i to r_o (L=8 at K=5). Stages: window, multiply, clog2(K*K) tree levels, round/saturate.
- dv/hs/vs pass through an L-deep shift register; output edges are exactly L cycles after input edges.
- Load duration: K*K+1 cycles from vs_i rise to busy fall.
- Commit: active bank takes the new values in the cycle after vs_i falls. Pixels entering the window from that cycle onward use the new kernel.
- Reset values:
  - All outputs 0; coeff_err_o=0; FSM in IDLE.
  - Window and pipeline cleared.
  - Active and shadow banks set to identity: centre = 2^FRAC, all other coefficients 0.
- Reset asserted mid-load aborts the load; the identity kernel is restored.

## Structure
- Package fir2d_pkg holds:
  - KMAX=7 and ADDR_W=6.
  - Loader state enum.
  - ACCW and tree-depth functions of K, PW, CW.
  - Identity-kernel constant generator.
- Sub-module fir2d_coeff_loader: FSM, address counter, shadow bank, commit strobe, error flag. It exports the active bank as a flat K*K*CW vector.
- Top holds the window, multipliers, adder tree, round/saturate and the sync delay line.

## Test plan
- After reset, no load: ramp column input with all rows equal to n → r_o = n after 8 cycles (identity); g_o = b_o = r_o.
- Load an all-16'h0100/25 ≈ 16'h000A kernel, then commit; constant 200 input → 200*10*25/256 rounded = 195.
- Load a Laplacian (centre 16'h1000, ring 16'hFF00/16'hFE00), flat 128 field → result clips to 255 at edges, 0 in flat interior. With ABS_MODE=1, a negative response becomes its magnitude.
- Pulse vs_i high for only 10 cycles at K=5 → no commit, coeff_err_o=1, output unchanged from the previous kernel.
- Random dv/hs/vs pattern → output syncs equal the inputs delayed by exactly L; frame-straddling kernel change takes effect only on the first post-commit pixel.
- Assert rst during LOAD → all outputs 0 immediately; after release, identity passthrough.
